// File: rtl/matrix_mult_scheduler_pkg.sv
// Shared types and helpers for the matrix multiply scheduler and its column processor.
// The arithmetic helpers implement a reduced fp32 (truncating, subnormals flushed to zero).
package matrix_mult_scheduler_pkg;

   localparam int unsigned SIZE_DEF       = 4;
   localparam int unsigned CELL_WIDTH_DEF = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } sched_state_t;

   typedef enum logic [1:0] {
      P_IDLE = 2'd0,
      P_CALC = 2'd1,
      P_DONE = 2'd2
   } proc_state_t;

   typedef struct packed {
      logic        sign;
      logic [7:0]  expo;
      logic [22:0] mant;
   } fp32_t;

   // Bit offset of element (r,c) in a row-major flattened matrix.
   function automatic int unsigned elem_offset(input int unsigned r, input int unsigned c,
                                               input int unsigned size,
                                               input int unsigned cell_width);
      return (r * size + c) * cell_width;
   endfunction

   function automatic fp32_t fp_mul(input fp32_t a, input fp32_t b);
      fp32_t              r;
      logic [47:0]        prod;
      logic signed [9:0]  e;
      r    = '0;
      prod = '0;
      e    = '0;
      if (a.expo != 8'd0 && b.expo != 8'd0) begin
         prod = {24'd0, 1'b1, a.mant} * {24'd0, 1'b1, b.mant};
         e    = $signed({2'b00, a.expo}) + $signed({2'b00, b.expo}) - 10'sd127;
         if (prod[47]) begin
            r.mant = prod[46:24];
            e      = e + 10'sd1;
         end else begin
            r.mant = prod[45:23];
         end
         r.sign = a.sign ^ b.sign;
         if (e <= 10'sd0)        r = '0;
         else if (e >= 10'sd255) r = {a.sign ^ b.sign, 8'hFF, 23'd0};
         else                    r.expo = e[7:0];
      end
      return r;
   endfunction

   function automatic fp32_t fp_add(input fp32_t a, input fp32_t b);
      fp32_t              r;
      fp32_t              x;
      fp32_t              y;
      logic [7:0]         d;
      logic [24:0]        ux;
      logic [24:0]        uy;
      logic [24:0]        s;
      logic signed [9:0]  e;
      r  = '0;
      x  = a;
      y  = b;
      d  = '0;
      ux = '0;
      uy = '0;
      s  = '0;
      e  = '0;
      if (a.expo == 8'd0) begin
         r = (b.expo == 8'd0) ? '0 : b;
      end else if (b.expo == 8'd0) begin
         r = a;
      end else begin
         if ({a.expo, a.mant} < {b.expo, b.mant}) begin
            x = b;
            y = a;
         end
         d  = x.expo - y.expo;
         ux = {2'b01, x.mant};
         uy = (d > 8'd24) ? 25'd0 : ({2'b01, y.mant} >> d);
         e  = $signed({2'b00, x.expo});
         if (x.sign == y.sign) begin
            s = ux + uy;
            if (s[24]) begin
               r.mant = s[23:1];
               e      = e + 10'sd1;
            end else begin
               r.mant = s[22:0];
            end
         end else begin
            s = ux - uy;
            // Renormalise after cancellation, one bit position per step.
            for (int n = 0; n < 24; n++) begin
               if (!s[23] && s != 25'd0) begin
                  s = s << 1;
                  e = e - 10'sd1;
               end
            end
            r.mant = s[22:0];
         end
         r.sign = x.sign;
         if (s == 25'd0 || e <= 10'sd0) r = '0;
         else if (e >= 10'sd255)        r = {x.sign, 8'hFF, 23'd0};
         else                           r.expo = e[7:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/matrix_mult_scheduler_if.sv
// Start/result handshake bundle between the register file and the matrix multiply scheduler.
interface matrix_mult_scheduler_if
   import matrix_mult_scheduler_pkg::*;
#(
   parameter int unsigned size       = SIZE_DEF,
   parameter int unsigned cell_width = CELL_WIDTH_DEF
);
   localparam int unsigned width     = cell_width * size;
   localparam int unsigned mat_width = width * size;
   localparam int unsigned idx_width = $clog2(size * size);

   logic                 in_ready;
   logic [mat_width-1:0] in_mat_a;
   logic [mat_width-1:0] in_mat_b;
   logic                 out_ack;
   logic [mat_width-1:0] out_mat_c;
   logic                 out_ready;
   logic                 out_busy;
   logic [idx_width-1:0] out_cell_idx;

   modport master (
      output in_ready, in_mat_a, in_mat_b, out_ack,
      input  out_mat_c, out_ready, out_busy, out_cell_idx
   );

   modport slave (
      input  in_ready, in_mat_a, in_mat_b, out_ack,
      output out_mat_c, out_ready, out_busy, out_cell_idx
   );
endinterface

// File: rtl/matrix_mult_scheduler_column_processor.sv
// Dot product of one row and one column: one fp32 multiply-accumulate per cycle,
// result held with out_ready until out_ack. Assumes cell_width = 32.
module column_processor
   import matrix_mult_scheduler_pkg::*;
#(
   parameter int unsigned size       = SIZE_DEF,
   parameter int unsigned cell_width = CELL_WIDTH_DEF
) (
   input  logic                          in_clk,
   input  logic                          in_reset,
   input  logic                          in_ready,
   input  logic [cell_width*size-1:0]    in_row_a,
   input  logic [cell_width*size-1:0]    in_col_b,
   output logic [cell_width*size-1:0]    out_cell_c,
   output logic                          out_ready,
   input  logic                          out_ack
);
   localparam int unsigned width = cell_width * size;
   localparam int unsigned k_w   = (size > 1) ? $clog2(size) : 1;

   proc_state_t      state, state_nx;
   logic [width-1:0] row_q, row_nx;
   logic [width-1:0] col_q, col_nx;
   fp32_t            acc, acc_nx;
   logic [k_w-1:0]   k, k_nx;
   logic             ready_q, ready_nx;
   logic [width-1:0] cell_q, cell_nx;
   fp32_t            elem_a_c;
   fp32_t            elem_b_c;
   fp32_t            prod_c;

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         state   <= P_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         acc     <= '0;
         k       <= '0;
         ready_q <= 1'b0;
         cell_q  <= '0;
      end else begin
         state   <= state_nx;
         row_q   <= row_nx;
         col_q   <= col_nx;
         acc     <= acc_nx;
         k       <= k_nx;
         ready_q <= ready_nx;
         cell_q  <= cell_nx;
      end
   end

   always_comb begin
      state_nx = state;
      row_nx   = row_q;
      col_nx   = col_q;
      acc_nx   = acc;
      k_nx     = k;
      ready_nx = ready_q;
      cell_nx  = cell_q;
      elem_a_c = row_q[32'(k) * cell_width +: cell_width];
      elem_b_c = col_q[32'(k) * cell_width +: cell_width];
      prod_c   = fp_mul(elem_a_c, elem_b_c);
      case (state)
         P_IDLE: begin
            if (in_ready) begin
               row_nx   = in_row_a;
               col_nx   = in_col_b;
               acc_nx   = '0;
               k_nx     = '0;
               state_nx = P_CALC;
            end
         end
         P_CALC: begin
            acc_nx = fp_add(acc, prod_c);
            if (k == k_w'(size - 1)) begin
               cell_nx  = width'(acc_nx);
               ready_nx = 1'b1;
               state_nx = P_DONE;
            end else begin
               k_nx = k + 1'b1;
            end
         end
         P_DONE: begin
            if (out_ack) begin
               ready_nx = 1'b0;
               state_nx = P_IDLE;
            end
         end
         default: state_nx = P_IDLE;
      endcase
   end

   assign out_cell_c = cell_q;
   assign out_ready  = ready_q;

endmodule

// File: rtl/matrix_mult_scheduler.sv
// Computes C = A*B by sequencing one column_processor over every output cell in
// row-major order; A and B are latched at start, C is presented with ready/ack.
module matrix_mult_scheduler
   import matrix_mult_scheduler_pkg::*;
#(
   parameter int unsigned size       = SIZE_DEF,
   parameter int unsigned cell_width = CELL_WIDTH_DEF
) (
   input  logic                    in_clk,
   input  logic                    in_reset,
   matrix_mult_scheduler_if.slave  bus
);
   localparam int unsigned width     = cell_width * size;
   localparam int unsigned mat_width = width * size;
   localparam int unsigned idx_width = $clog2(size * size);
   localparam int unsigned row_w     = (size > 1) ? $clog2(size) : 1;

   sched_state_t         state, state_nx;
   logic [mat_width-1:0] mat_a, mat_a_nx;
   logic [mat_width-1:0] mat_b, mat_b_nx;
   logic [mat_width-1:0] mat_c, mat_c_nx;
   logic [row_w-1:0]     i, i_nx;
   logic [row_w-1:0]     j, j_nx;
   logic [idx_width-1:0] cell_idx, cell_idx_nx;
   logic                 busy, busy_nx;
   logic                 ready, ready_nx;
   logic                 proc_in_ready, proc_in_ready_nx;
   logic                 proc_out_ack, proc_out_ack_nx;

   logic [width-1:0]     row_a_c;
   logic [width-1:0]     col_b_c;
   logic [width-1:0]     proc_cell_c;
   logic                 proc_out_ready;
   logic                 unused_upper;

   column_processor #(
      .size       (size),
      .cell_width (cell_width)
   ) col_proc_unit (
      .in_clk     (in_clk),
      .in_reset   (in_reset),
      .in_ready   (proc_in_ready),
      .in_row_a   (row_a_c),
      .in_col_b   (col_b_c),
      .out_cell_c (proc_cell_c),
      .out_ready  (proc_out_ready),
      .out_ack    (proc_out_ack)
   );

   // Only the low cell carries the dot product.
   assign unused_upper = ^proc_cell_c[width-1:cell_width];

   // Row i of A and column j of B gathered from the latched matrices.
   always_comb begin
      row_a_c = '0;
      col_b_c = '0;
      for (int unsigned k = 0; k < size; k++) begin
         row_a_c[k * cell_width +: cell_width] =
            mat_a[elem_offset(32'(i), k, size, cell_width) +: cell_width];
         col_b_c[k * cell_width +: cell_width] =
            mat_b[elem_offset(k, 32'(j), size, cell_width) +: cell_width];
      end
   end

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         state         <= S_IDLE;
         mat_a         <= '0;
         mat_b         <= '0;
         mat_c         <= '0;
         i             <= '0;
         j             <= '0;
         cell_idx      <= '0;
         busy          <= 1'b0;
         ready         <= 1'b0;
         proc_in_ready <= 1'b0;
         proc_out_ack  <= 1'b0;
      end else begin
         state         <= state_nx;
         mat_a         <= mat_a_nx;
         mat_b         <= mat_b_nx;
         mat_c         <= mat_c_nx;
         i             <= i_nx;
         j             <= j_nx;
         cell_idx      <= cell_idx_nx;
         busy          <= busy_nx;
         ready         <= ready_nx;
         proc_in_ready <= proc_in_ready_nx;
         proc_out_ack  <= proc_out_ack_nx;
      end
   end

   always_comb begin
      state_nx        = state;
      mat_a_nx        = mat_a;
      mat_b_nx        = mat_b;
      mat_c_nx        = mat_c;
      i_nx            = i;
      j_nx            = j;
      busy_nx         = busy;
      ready_nx        = ready;
      proc_out_ack_nx = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.in_ready) begin
               mat_a_nx = bus.in_mat_a;
               mat_b_nx = bus.in_mat_b;
               mat_c_nx = '0;
               i_nx     = '0;
               j_nx     = '0;
               busy_nx  = 1'b1;
               state_nx = S_ISSUE;
            end
         end
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT: begin
            if (proc_out_ready) begin
               mat_c_nx[elem_offset(32'(i), 32'(j), size, cell_width) +: cell_width] =
                  proc_cell_c[cell_width-1:0];
               proc_out_ack_nx = 1'b1;
               state_nx        = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Wait for the processor to drop its result so a cell is never captured twice.
            if (!proc_out_ready) begin
               if (i == row_w'(size - 1) && j == row_w'(size - 1)) begin
                  busy_nx  = 1'b0;
                  ready_nx = 1'b1;
                  state_nx = S_DONE;
               end else begin
                  if (j == row_w'(size - 1)) begin
                     j_nx = '0;
                     i_nx = i + 1'b1;
                  end else begin
                     j_nx = j + 1'b1;
                  end
                  state_nx = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            if (bus.out_ack) begin
               ready_nx = 1'b0;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
      proc_in_ready_nx = (state_nx == S_ISSUE);
      cell_idx_nx      = idx_width'(32'(i_nx) * size + 32'(j_nx));
   end

   assign bus.out_mat_c    = mat_c;
   assign bus.out_ready    = ready;
   assign bus.out_busy     = busy;
   assign bus.out_cell_idx = cell_idx;

endmodule

// File: tb/tb_matrix_mult_scheduler.sv
// Directed bench for matrix_mult_scheduler; expected C comes from a real-valued
// matrix product converted back to fp32 bits.
module tb_matrix_mult_scheduler;
   import matrix_mult_scheduler_pkg::*;

   localparam int MW = 512;

   logic in_clk;
   logic in_reset;

   matrix_mult_scheduler_if #(.size(4), .cell_width(32)) bus ();

   matrix_mult_scheduler #(.size(4), .cell_width(32)) dut (
      .in_clk   (in_clk),
      .in_reset (in_reset),
      .bus      (bus)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   int          vectors    = 0;
   int          miscompares = 0;
   int          pulses     = 0;
   int          steps      = 0;
   logic [MW-1:0] exp_c;
   logic        prev_busy  = 1'b0;
   logic [3:0]  prev_idx   = '0;

   task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", nm, act, expv);
      end
   endtask

   function automatic real b2r(input logic [31:0] v);
      real r;
      int  e;
      if (v[30:23] == 8'd0) return 0.0;
      r = 1.0 + real'(v[22:0]) / 8388608.0;
      e = int'(v[30:23]) - 127;
      while (e > 0) begin r = r * 2.0; e--; end
      while (e < 0) begin r = r / 2.0; e++; end
      return v[31] ? -r : r;
   endfunction

   function automatic logic [31:0] r2b(input real v);
      logic s;
      int   e;
      int   m;
      if (v == 0.0) return 32'd0;
      s = (v < 0.0);
      if (s) v = -v;
      e = 127;
      while (v >= 2.0) begin v = v / 2.0; e++; end
      while (v < 1.0)  begin v = v * 2.0; e--; end
      m = $rtoi((v - 1.0) * 8388608.0);
      return {s, e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] el(input logic [MW-1:0] m, input int r, input int c);
      return m[(r * 4 + c) * 32 +: 32];
   endfunction

   function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int r, input int c,
                                         input logic [31:0] v);
      m[(r * 4 + c) * 32 +: 32] = v;
      return m;
   endfunction

   // C(r,c) = sum_k A(r,k)*B(k,c) in real arithmetic.
   function automatic logic [MW-1:0] model(input logic [MW-1:0] a, input logic [MW-1:0] b);
      logic [MW-1:0] c;
      real acc;
      c = '0;
      for (int r = 0; r < 4; r++)
         for (int cc = 0; cc < 4; cc++) begin
            acc = 0.0;
            for (int k = 0; k < 4; k++) acc = acc + b2r(el(a, r, k)) * b2r(el(b, k, cc));
            c = put(c, r, cc, r2b(acc));
         end
      return c;
   endfunction

   // Per-cycle checks: C against the model while valid, cell index strictly row-major.
   always @(negedge in_clk) begin
      if (!in_reset) begin
         prev_busy = 1'b0;
      end else begin
         if (bus.out_ready) begin
            chk("c_model", bus.out_mat_c, exp_c);
            chk("busy_in_done", MW'(bus.out_busy), MW'(0));
         end
         if (bus.out_busy) begin
            if (!prev_busy) chk("idx_start", MW'(bus.out_cell_idx), MW'(0));
            else if (bus.out_cell_idx != prev_idx) begin
               chk("idx_step", MW'(bus.out_cell_idx), MW'(prev_idx + 4'd1));
               steps++;
            end
         end
         prev_busy = bus.out_busy;
         prev_idx  = bus.out_cell_idx;
      end
   end

   always @(posedge in_clk) if (in_reset && dut.proc_in_ready) pulses++;

   task automatic start(input logic [MW-1:0] a, input logic [MW-1:0] b);
      bus.in_mat_a = a;
      bus.in_mat_b = b;
      exp_c        = model(a, b);
      bus.in_ready = 1'b1;
      @(negedge in_clk);
      bus.in_ready = 1'b0;
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (!bus.out_ready && n < 400) begin @(negedge in_clk); n++; end
      chk(nm, MW'(bus.out_ready), MW'(1));
   endtask

   task automatic do_ack(input string nm);
      bus.out_ack = 1'b1;
      @(negedge in_clk);
      bus.out_ack = 1'b0;
      chk(nm, MW'(bus.out_ready), MW'(0));
   endtask

   logic [MW-1:0] a_id, b_seq, a_two, a_sm, b_sm, all_two;
   int p0;

   initial begin
      a_id = '0; b_seq = '0; a_two = '0; a_sm = '0; b_sm = '0; all_two = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            a_id    = put(a_id, r, c, (r == c) ? 32'h3F800000 : 32'h0);
            b_seq   = put(b_seq, r, c, r2b(real'(r * 4 + c + 1)));
            a_two   = put(a_two, r, c, 32'h40000000);
            all_two = put(all_two, r, c, 32'h40000000);
            a_sm    = put(a_sm, r, c, r2b(real'((r + c) % 3)));
            b_sm    = put(b_sm, r, c, r2b(real'((r * c + 1) % 4)));
         end
      exp_c        = '0;
      bus.in_ready = 1'b0;
      bus.in_mat_a = '0;
      bus.in_mat_b = '0;
      bus.out_ack  = 1'b0;
      in_reset     = 1'b0;

      // Model pins
      chk("pin_r2b_3", MW'(r2b(3.0)), MW'(32'h40400000));
      chk("pin_b16", MW'(el(b_seq, 3, 3)), MW'(32'h41800000));

      repeat (2) @(negedge in_clk);
      chk("rst_c", bus.out_mat_c, '0);
      chk("rst_ready", MW'(bus.out_ready), MW'(0));
      chk("rst_busy", MW'(bus.out_busy), MW'(0));
      chk("rst_idx", MW'(bus.out_cell_idx), MW'(0));
      in_reset = 1'b1;
      @(negedge in_clk);

      // Identity * B == B, with a 20-cycle delayed ack
      start(a_id, b_seq);
      chk("busy_after_start", MW'(bus.out_busy), MW'(1));
      wait_ready("id_done");
      chk("id_c_eq_b", bus.out_mat_c, b_seq);
      chk("id_c33", MW'(el(bus.out_mat_c, 3, 3)), MW'(32'h41800000));
      p0 = pulses;
      for (int n = 0; n < 20; n++) begin
         @(negedge in_clk);
         chk("hold_ready", MW'(bus.out_ready), MW'(1));
      end
      chk("no_issue_in_done", MW'(pulses), MW'(p0));
      do_ack("id_ack_drop");

      // 2.0 everywhere * identity, 16 issues in row-major order
      pulses = 0;
      steps  = 0;
      start(a_two, a_id);
      wait_ready("two_done");
      chk("two_c", bus.out_mat_c, all_two);
      chk("two_idx_done", MW'(bus.out_cell_idx), MW'(15));
      chk("two_pulses", MW'(pulses), MW'(16));
      chk("two_steps", MW'(steps), MW'(15));
      do_ack("two_ack_drop");

      // in_ready held high with inputs changing mid-run
      pulses       = 0;
      bus.in_mat_a = a_sm;
      bus.in_mat_b = b_sm;
      exp_c        = model(a_sm, b_sm);
      bus.in_ready = 1'b1;
      repeat (10) @(negedge in_clk);
      bus.in_mat_a = a_two;
      bus.in_mat_b = b_seq;
      wait_ready("hold_done");
      bus.in_ready = 1'b0;
      chk("hold_c", bus.out_mat_c, model(a_sm, b_sm));
      chk("hold_pulses", MW'(pulses), MW'(16));
      do_ack("hold_ack_drop");

      // Asynchronous reset while waiting on cell 7
      start(a_sm, b_seq);
      begin
         int n = 0;
         while (!(bus.out_cell_idx == 4'd7 && dut.state == S_WAIT) && n < 400) begin
            @(negedge in_clk); n++;
         end
         chk("reach_cell7", MW'(n < 400), MW'(1));
      end
      chk("busy_cell7", MW'(bus.out_busy), MW'(1));
      in_reset = 1'b0;
      #1;
      chk("arst_c", bus.out_mat_c, '0);
      chk("arst_busy", MW'(bus.out_busy), MW'(0));
      chk("arst_ready", MW'(bus.out_ready), MW'(0));
      chk("arst_idx", MW'(bus.out_cell_idx), MW'(0));
      chk("arst_state", MW'(dut.state), MW'(S_IDLE));
      @(negedge in_clk);
      in_reset = 1'b1;
      @(negedge in_clk);
      start(a_id, b_sm);
      wait_ready("post_rst_done");
      chk("post_rst_c", bus.out_mat_c, b_sm);

      // Back-to-back: ack, then start on the following cycle
      do_ack("b2b_ack1");
      start(a_id, b_seq);
      wait_ready("b2b_done");
      chk("b2b_c", bus.out_mat_c, b_seq);
      do_ack("b2b_ack2");

      repeat (2) @(negedge in_clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/matrix_mult_scheduler.md
Name: matrix_mult_scheduler

Overview:
- Sequences one `column_processor` over all size×size output cells to compute C = A·B.
- Latches the flattened A and B matrices on a start handshake.
- For each cell (i,j), issues row i of A and column j of B to the processor, collects the result and stores it into a C register.
- Presents the full C with a ready/ack handshake. Sits between the bus-facing register file and the column datapath.

Parameters:
- size, 4, matrix dimension (square size×size).
- cell_width, 32, bits per matrix element.
- width, cell_width*size, bits per row/column vector (processor vector width).
- mat_width, width*size, bits per flattened matrix.

Ports:
- in_clk  input  1  clock, all state on rising edge.
- in_reset  input  1  asynchronous active-low reset; also drives the internal processor's in_reset.
- in_ready  input  1  start request; sampled only in S_IDLE.
- in_mat_a  input  mat_width  A, row-major: A(r,c) at bits [(r*size+c)*cell_width +: cell_width].
- in_mat_b  input  mat_width  B, same layout.
- out_ack  input  1  consumer acknowledge of out_mat_c.
- out_mat_c  output  mat_width  C, same layout.
- out_ready  output  1  C valid; held until out_ack.
- out_busy  output  1  high from start acceptance until S_DONE is entered.
- out_cell_idx  output  $clog2(size*size)  linear index i*size+j of the cell in progress.

Behaviour:
- Reset (async, in_reset=0): out_mat_c=0, out_ready=0, out_busy=0, out_cell_idx=0; i=j=0; latched A/B=0; proc in_ready=0, proc out_ack=0; state S_IDLE. Reset mid-operation aborts immediately, and the processor is reset by the same net.
- S_IDLE:
  - If in_ready=1: latch in_mat_a/in_mat_b, clear out_mat_c, set i=j=0, out_busy=1, then go to S_ISSUE.
  - in_ready while not in S_IDLE is ignored (no queueing).
- S_ISSUE:
  - Drive proc in_row_a = row i of latched A (slot k = A(i,k)).
  - Drive proc in_col_b = column j of latched B (slot k = B(k,j), slot k at bits [k*cell_width +: cell_width]).
  - Proc in_ready=1 for exactly this one cycle. Next state: S_WAIT.
- S_WAIT:
  - Proc in_ready=0; row/col inputs hold.
  - When proc out_ready=1: write proc out_cell_c[cell_width-1:0] into C(i,j), assert proc out_ack=1 for one cycle, go to S_DRAIN.
  - No timeout.
- S_DRAIN:
  - Proc out_ack=0; wait until proc out_ready=0. This guarantees the processor has returned to idle and prevents double capture.
  - Then, if (i,j)=(size-1,size-1), go to S_DONE.
  - Otherwise advance and return to S_ISSUE: j+1, or j=0 and i+1 when j=size-1.
- S_DONE: out_ready=1, out_busy=0, out_mat_c stable. On out_ack=1, go to S_IDLE and out_ready=0 next cycle.
- out_cell_idx = i*size+j, updated with the indices. It is size*size-1 in S_DONE and returns to 0 on the next start.
- The processor's upper (width-cell_width) result bits are ignored.
- Cells are computed strictly in row-major order.
- out_mat_c is written one cell at a time and is valid only while out_ready=1.
- Scheduler overhead per cell is 3 cycles (ISSUE, one ack cycle, DRAIN exit) plus the processor latency L. Total ≈ size*size*(L+3)+2 cycles from in_ready to out_ready.

Decomposition:
- Shared package/header holds:
  - State encodings: S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE (3-bit).
  - Default size/cell_width.
  - Element-offset helper function: (r,c)→bit offset.
- One sub-module instance: `column_processor` (col_proc_unit), parameters passed through.
- Row/column gather is combinational muxing inside this block; no further sub-modules.

Test Plan:
- A=identity (diag 0x3F800000, else 0), B(r,c)=float(r*4+c+1) → C==B bit-exact; out_ready stays high until out_ack, then drops the next cycle.
- A(r,c)=0x40000000 (2.0) everywhere, B=identity → every C element 0x40000000; out_cell_idx steps 0..15 in row-major order, and exactly 16 proc in_ready pulses occur.
- in_ready held high throughout a run and inputs changed mid-run → result uses the originally latched matrices; no restart until S_IDLE.
- Assert in_reset=0 while in S_WAIT at cell 7 → all outputs 0 asynchronously, state S_IDLE; a subsequent start completes correctly.
- Delay out_ack 20 cycles after out_ready → out_mat_c and out_ready stable throughout, no proc in_ready issued.
- Back-to-back: out_ack and in_ready asserted in consecutive cycles → second run is accepted from S_IDLE and its C replaces the first.
